math_multiplier_carrysave: RTL and testbench

Unsigned N×N-bit array multiplier that uses a carry-save adder array with a final carry-propagate row. The full 2N-bit product is registered once. It is the carry-save member of the math multiplier family and is used wherever a single-cycle-latency, fully parallel unsigned product is needed. The datapath is combinational and the output is registered, with no handshake.

---
 rtl/math_multiplier_carrysave_pkg.sv | 7 +
 rtl/math_multiplier_carrysave_fa.sv | 16 +
 rtl/math_multiplier_carrysave.sv | 96 +++++++++
 tb/tb_math_multiplier_carrysave.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/math_multiplier_carrysave_pkg.sv
// Shared constants for the carry-save array multiplier.
// Holds the default operand width used by the top.
package math_multiplier_carrysave_pkg;

   localparam int MUL_N_DEFAULT = 4;

endpackage

// File: rtl/math_multiplier_carrysave_fa.sv
// One-bit full adder cell.
// Used in both the carry-save array and the final ripple row.
module math_multiplier_carrysave_fa
   import math_multiplier_carrysave_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/math_multiplier_carrysave.sv
// Unsigned NxN carry-save array multiplier.
// Combinational array plus ripple merge, one output register.
module math_multiplier_carrysave
   import math_multiplier_carrysave_pkg::*;
#(
   parameter int N = MUL_N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   logic [N-1:0]   prod_lo;
   logic [N-1:0]   prod_hi;
   logic [2*N-1:0] p_d;
   logic [2*N-1:0] p_q;

   genvar i, j, k;

   // Row i: sum bit j and carry bit j both weigh i+j and i+j+1.
   for (i = 0; i < N; i++) begin : gen_row
      logic [N-1:0] pp;
      logic [N-1:0] sum;
      logic [N-1:0] cry;

      assign pp = a & {N{b[i]}};

      if (i == 0) begin : gen_init
         assign sum = pp;
         assign cry = '0;
      end else begin : gen_csa
         for (j = 0; j < N; j++) begin : gen_col
            logic y_in;

            // Top cell has no shifted sum above it.
            if (j < N - 1) begin : gen_mid
               assign y_in = gen_row[i-1].sum[j+1];
            end else begin : gen_top
               assign y_in = 1'b0;
            end

            math_multiplier_carrysave_fa u_fa (
               .x    (pp[j]),
               .y    (y_in),
               .cin  (gen_row[i-1].cry[j]),
               .s    (sum[j]),
               .cout (cry[j])
            );
         end
      end

      assign prod_lo[i] = sum[0];
   end

   // Ripple merge of the last row's sum and carry vectors.
   for (k = 0; k < N - 1; k++) begin : gen_rca
      logic ci;
      logic co;

      if (k == 0) begin : gen_lsb
         assign ci = 1'b0;
      end else begin : gen_chain
         assign ci = gen_rca[k-1].co;
      end

      math_multiplier_carrysave_fa u_fa (
         .x    (gen_row[N-1].sum[k+1]),
         .y    (gen_row[N-1].cry[k]),
         .cin  (ci),
         .s    (prod_hi[k]),
         .cout (co)
      );
   end

   // Product < 2^(2N), so these two can never both be set.
   assign prod_hi[N-1] = gen_row[N-1].cry[N-1] | gen_rca[N-2].co;

   // Assemble the full product for the output register.
   always_comb begin
      p_d = {prod_hi, prod_lo};
   end

   // Load the product every edge; async clear on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: tb/tb_math_multiplier_carrysave.sv
// Self-checking bench for the carry-save multiplier.
// Covers N=4 and N=8 instances against plain a*b.
module tb_math_multiplier_carrysave;

   logic        clk;
   logic        rst_n;
   logic [3:0]  a4;
   logic [3:0]  b4;
   logic [7:0]  p4;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [15:0] p8;
   logic [15:0] wide_a;
   logic [15:0] wide_b;

   int n_chk;
   int n_err;

   math_multiplier_carrysave #(.N(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a4),
      .b     (b4),
      .p     (p4)
   );

   math_multiplier_carrysave #(.N(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a8),
      .b     (b8),
      .p     (p8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mul(input int x, input int y);
      return 16'(x * y);
   endfunction

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step4(input string tag, input logic [3:0] x,
                        input logic [3:0] y);
      @(negedge clk);
      a4 = x;
      b4 = y;
      @(posedge clk);
      #1;
      check(tag, {8'h00, p4}, ref_mul(int'(x), int'(y)));
   endtask

   task automatic step8(input string tag, input logic [7:0] x,
                        input logic [7:0] y);
      @(negedge clk);
      a8 = x;
      b8 = y;
      @(posedge clk);
      #1;
      check(tag, p8, ref_mul(int'(x), int'(y)));
   endtask

   initial begin
      logic [3:0] pa [4];
      logic [3:0] pb [4];
      int         ph;

      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      a4    = 4'hF;
      b4    = 4'hF;
      a8    = 8'hFF;
      b8    = 8'hFF;

      // Reset holds p at zero across edges.
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold4", {8'h00, p4}, 16'h0000);
      check("rst_hold8", p8, 16'h0000);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rel", {8'h00, p4}, 16'h00E1);

      // Upper bits beyond the port width are dropped.
      @(negedge clk);
      wide_a = 16'hF00D;
      wide_b = 16'h0DAD;
      a4 = wide_a[3:0];
      b4 = wide_b[3:0];
      @(posedge clk);
      #1;
      check("trunc", {8'h00, p4}, 16'h00A9);

      // Exhaustive with a random rotation of the a sweep.
      ph = int'($urandom_range(0, 15));
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            step4("exh", 4'((x + ph) % 16), 4'(y));
         end
      end

      // Back-to-back sequence.
      pa[0] = 4'd3;  pb[0] = 4'd5;
      pa[1] = 4'd15; pb[1] = 4'd1;
      pa[2] = 4'd0;  pb[2] = 4'd9;
      pa[3] = 4'd10; pb[3] = 4'd10;
      for (int i = 0; i < 4; i++) begin
         step4("b2b", pa[i], pb[i]);
      end

      // Mid-stream reset clears p before the next edge.
      step4("pre_rst", 4'hF, 4'hF);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst", {8'h00, p4}, 16'h0000);
      @(negedge clk);
      a4    = 4'd7;
      b4    = 4'd9;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst", {8'h00, p4}, 16'd63);

      // Random N=4 pairs.
      for (int i = 0; i < 32; i++) begin
         step4("rnd4", 4'($urandom), 4'($urandom));
      end

      // N=8 corners then random pairs.
      step8("c8_max", 8'd255, 8'd255);
      step8("c8_pow", 8'd128, 8'd2);
      step8("c8_one", 8'd1, 8'd255);
      step8("c8_zero", 8'd0, 8'd200);
      for (int i = 0; i < 200; i++) begin
         step8("rnd8", 8'($urandom), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
